// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page
// holding a free-running cycle counter, a status register and a drained output FIFO.
module dmem_responder #(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [5:0] OFF_CYCLE  = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_TX     = 6'h02;
    localparam logic [5:0] OFF_CTRL   = 6'h03;

    // Handshake: a FIFO word transfers on a rising edge where out_valid and
    // out_ready are both high; out_data is held while out_valid=1 and out_ready=0.

    logic [31:0]   ram_q  [DEPTH];
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [31:0]   cycle_q,  cycle_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          mis_q,    mis_d;
    logic          drop_q,   drop_d;

    logic          is_mmio;
    logic          aligned;
    logic [5:0]    word_off;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          push;
    logic          pop;
    logic          accept;
    logic          clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   status;

    assign is_mmio  = (addr[31:8] == 24'hFF_FFFF);
    assign aligned  = (addr[1:0] == 2'b00);
    assign word_off = addr[7:2];
    assign ram_idx  = addr[AW+1:2];

    assign ram_we = memwrite & aligned & ~is_mmio;
    assign push   = memwrite & aligned & is_mmio & (word_off == OFF_TX);
    assign clr    = memwrite & aligned & is_mmio & (word_off == OFF_CTRL) & writedata[0];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept     = push & (~fifo_full | pop);

    always_comb begin
        cycle_d  = cycle_q + 32'd1;
        rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CW'(1);
        end
        // A new error in the clearing cycle keeps the flag set.
        mis_d  = (memwrite & ~aligned) | (mis_q & ~clr);
        drop_d = (push & ~accept) | (drop_q & ~clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mis_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            cycle_q  <= cycle_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mis_q    <= mis_d;
            drop_q   <= drop_d;
        end
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= writedata;
        end
        if (accept) begin
            fifo_q[wr_ptr_q] <= writedata;
        end
    end

    assign status = {20'd0, drop_q, mis_q, fifo_full, fifo_empty, 8'(count_q)};

    always_comb begin
        readdata = '0;
        if (is_mmio) begin
            case (word_off)
                OFF_CYCLE:  readdata = cycle_q;
                OFF_STATUS: readdata = status;
                default:    readdata = '0;
            endcase
        end else begin
            readdata = ram_q[ram_idx];
        end
    end

    assign out_data     = fifo_q[rd_ptr_q];
    assign misalign_err = mis_q;

endmodule
